// File: rtl/line_clear_pkg.sv
// Shared playfield geometry, cell width and line-clear FSM encodings.
// CELL_IDX gives the bit offset of cell (x,y) in a flattened board vector.
package line_clear_pkg;

   localparam int unsigned BRICK_LEN  = 3;
   localparam int unsigned BOARD_ROWS = 20;
   localparam int unsigned BOARD_COLS = 10;

   localparam logic [1:0] LC_IDLE = 2'd0;
   localparam logic [1:0] LC_SCAN = 2'd1;
   localparam logic [1:0] LC_FILL = 2'd2;
   localparam logic [1:0] LC_DONE = 2'd3;

   function automatic int unsigned cell_idx(input int unsigned x, input int unsigned y);
      return (y * BOARD_COLS + x) * BRICK_LEN;
   endfunction

endpackage

`ifndef CELL_IDX
`define CELL_IDX(x, y) (((y) * line_clear_pkg::BOARD_COLS + (x)) * line_clear_pkg::BRICK_LEN)
`endif

// File: rtl/line_clear_row_full.sv
// Combinational full-row detector: high when every cell of the row is non-zero.
module row_full
   import line_clear_pkg::*;
#(
   parameter int unsigned COLS   = BOARD_COLS,
   parameter int unsigned CELL_W = BRICK_LEN
) (
   input  logic [COLS*CELL_W-1:0] row,
   output logic                   full
);

   always_comb begin
      full = 1'b1;
      for (int unsigned i = 0; i < COLS; i++) begin
         if (row[i*CELL_W +: CELL_W] == '0) begin
            full = 1'b0;
         end
      end
   end

endmodule

// File: rtl/line_clear.sv
// Sequential line-clear engine: snapshots the board, compacts full rows out
// bottom-up one row per cycle, zero-fills the top and reports cleared lines.
module line_clear
   import line_clear_pkg::*;
#(
   parameter int unsigned ROWS   = BOARD_ROWS,
   parameter int unsigned COLS   = BOARD_COLS,
   parameter int unsigned CELL_W = BRICK_LEN,
   parameter int unsigned TOT_W  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [ROWS*COLS*CELL_W-1:0] board_in,
   input  logic                        clr_total,
   output logic                        busy,
   output logic                        done,
   output logic [ROWS*COLS*CELL_W-1:0] board_out,
   output logic [2:0]                  lines,
   output logic [TOT_W-1:0]            lines_total
);

   localparam int unsigned ROW_W = COLS * CELL_W;
   localparam int unsigned BRD_W = ROWS * ROW_W;
   localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CW    = $clog2(ROWS + 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

   logic [1:0]       state_q, state_d;
   logic [BRD_W-1:0] work_q, work_d;
   logic [BRD_W-1:0] board_q, board_d;
   logic [RW-1:0]    r_q, r_d;
   logic [RW-1:0]    w_q, w_d;
   logic [CW-1:0]    c_q, c_d;
   logic             done_q, done_d;
   logic [2:0]       lines_q, lines_d;
   logic [TOT_W-1:0] tot_q, tot_d;
   logic [TOT_W:0]   tot_sum;
   logic [ROW_W-1:0] row_r;
   logic             row_is_full;

   assign row_r = work_q[int'(r_q)*ROW_W +: ROW_W];

   row_full #(
      .COLS   (COLS),
      .CELL_W (CELL_W)
   ) u_row_full (
      .row  (row_r),
      .full (row_is_full)
   );

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      r_d     = r_q;
      w_d     = w_q;
      c_d     = c_q;
      board_d = board_q;
      lines_d = lines_q;
      done_d  = 1'b0;
      tot_d   = tot_q;
      tot_sum = {1'b0, tot_q} + (TOT_W+1)'(c_q);

      case (state_q)
         LC_IDLE: begin
            if (start) begin
               work_d  = board_in;
               r_d     = LAST_ROW;
               w_d     = LAST_ROW;
               c_d     = '0;
               state_d = LC_SCAN;
            end
         end
         LC_SCAN: begin
            if (row_is_full) begin
               c_d = c_q + CW'(1);
            end else begin
               work_d[int'(w_q)*ROW_W +: ROW_W] = row_r;
               w_d = w_q - RW'(1);
            end
            r_d = r_q - RW'(1);
            if (r_q == '0) begin
               state_d = (c_d != '0) ? LC_FILL : LC_DONE;
            end
         end
         LC_FILL: begin
            // w enters FILL at c-1, so finishing at row 0 gives exactly c fill cycles
            work_d[int'(w_q)*ROW_W +: ROW_W] = '0;
            w_d = w_q - RW'(1);
            if (w_q == '0) begin
               state_d = LC_DONE;
            end
         end
         LC_DONE: begin
            tot_d   = tot_sum[TOT_W] ? '1 : tot_sum[TOT_W-1:0];
            state_d = LC_IDLE;
         end
         default: state_d = LC_IDLE;
      endcase

      // Results are captured on entry so they are already valid in the done cycle
      if (state_d == LC_DONE && state_q != LC_DONE) begin
         board_d = work_d;
         lines_d = (c_d > CW'(7)) ? 3'd7 : c_d[2:0];
         done_d  = 1'b1;
      end

      if (clr_total) begin
         tot_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= LC_IDLE;
         work_q  <= '0;
         board_q <= '0;
         r_q     <= '0;
         w_q     <= '0;
         c_q     <= '0;
         done_q  <= 1'b0;
         lines_q <= '0;
         tot_q   <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         board_q <= board_d;
         r_q     <= r_d;
         w_q     <= w_d;
         c_q     <= c_d;
         done_q  <= done_d;
         lines_q <= lines_d;
         tot_q   <= tot_d;
      end
   end

   assign busy        = (state_q != LC_IDLE);
   assign done        = done_q;
   assign board_out   = board_q;
   assign lines       = lines_q;
   assign lines_total = tot_q;

endmodule
